// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-ported dmem side of dmem_arbiter.
// slave is the arbiter's view; master is the requester/dmem environment's view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              wr0;
    logic              wr1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] address_dmem;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q_dmem;
    logic              busy;

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, wr0, wr1, q_dmem,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               address_dmem, data, wren, busy
    );

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, wr0, wr1, q_dmem,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               address_dmem, data, wren, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous dmem: one command in flight,
// ties broken against the last winner, read data returned two edges after the grant.
module dmem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input logic           clock,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_READ  = 2'b10
    } state_t;

    state_t            state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q,      owner_d;
    logic              rd_cmd_q,     rd_cmd_d;
    logic              gnt0_q,       gnt0_d;
    logic              gnt1_q,       gnt1_d;
    logic              rvalid0_q,    rvalid0_d;
    logic              rvalid1_q,    rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic              wren_q,       wren_d;
    logic              busy_q,       busy_d;
    logic              win_s;
    logic              win_wr_s;

    // Arbitration, command issue and read return; gnt/wren/rvalid default to a single-cycle pulse
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rd_cmd_d     = rd_cmd_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        addr_d       = addr_q;
        data_d       = data_q;
        wren_d       = 1'b0;
        win_s        = 1'b0;
        win_wr_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    win_s = ~last_grant_q;
                end else if (bus.req1) begin
                    win_s = 1'b1;
                end else begin
                    win_s = 1'b0;
                end
                win_wr_s = win_s ? bus.wr1 : bus.wr0;
                if (bus.req0 || bus.req1) begin
                    gnt0_d       = ~win_s;
                    gnt1_d       = win_s;
                    addr_d       = win_s ? bus.addr1  : bus.addr0;
                    data_d       = win_s ? bus.wdata1 : bus.wdata0;
                    wren_d       = win_wr_s;
                    rd_cmd_d     = ~win_wr_s;
                    last_grant_d = win_s;
                    owner_d      = win_s;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rd_cmd_q) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                // dmem sampled the address on the ISSUE edge, so q_dmem is valid now
                if (owner_q) begin
                    rdata1_d  = bus.q_dmem;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.q_dmem;
                    rvalid0_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rd_cmd_q     <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
            addr_q       <= {ADDR_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            wren_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rd_cmd_q     <= rd_cmd_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wren_q       <= wren_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.gnt0         = gnt0_q;
    assign bus.gnt1         = gnt1_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.address_dmem = addr_q;
    assign bus.data         = data_q;
    assign bus.wren         = wren_q;
    assign bus.busy         = busy_q;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12: dmem word-address width.
REQ-002 Parameter DATA_W, default 32: dmem data width.
REQ-003 Port clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; 0 = in reset.
REQ-005 Port req0 / req1, input, 1 each: access request from port 0 (processor) / port 1 (loader).
REQ-006 Port addr0 / addr1, input, ADDR_W each: request word address.
REQ-007 Port wdata0 / wdata1, input, DATA_W each: write data.
REQ-008 Port wr0 / wr1, input, 1 each: 1 = write, 0 = read.
REQ-009 Port gnt0 / gnt1, output, 1 each: one-cycle pulse; the port's command was accepted.
REQ-010 Port rvalid0 / rvalid1, output, 1 each: one-cycle pulse; rdataN holds read data.
REQ-011 Port rdata0 / rdata1, output, DATA_W each: registered read data per port.
REQ-012 Port address_dmem, output, ADDR_W: registered address to dmem.
REQ-013 Port data, output, DATA_W: registered write data to dmem.
REQ-014 Port wren, output, 1: registered dmem write enable.
REQ-015 Port q_dmem, input, DATA_W: dmem read data; valid in the cycle after the edge on which dmem samples address_dmem.
REQ-016 Port busy, output, 1: 1 whenever state is not IDLE.

Function
REQ-017 States: IDLE, ISSUE and READ only; all outputs are registered.
REQ-018 IDLE, no request sampled: remain in IDLE with gnt0, gnt1 and wren at 0.
REQ-019 IDLE, exactly one reqN sampled high: that port wins.
REQ-020 IDLE, both requests sampled high: the port not equal to the last_grant pointer wins.
REQ-021 Win at edge E0: gntW=1, address_dmem=addrW, data=wdataW, wren=wrW, last_grant=W, state=ISSUE, all for exactly one cycle.
REQ-022 ISSUE at edge E1: gnt and wren return to 0; address_dmem and data hold their values.
REQ-023 ISSUE next state: READ if the command is a read, IDLE if it is a write.
REQ-024 READ at edge E2: rdataW=q_dmem, rvalidW=1 for one cycle, state=IDLE.
REQ-025 Latency: read grant after E0, rvalid after E2; minimum spacing between accepts is 3 cycles (read) and 2 cycles (write).
REQ-026 Requests are sampled only in IDLE; a request asserted in ISSUE or READ waits.
REQ-027 Handshake: a requester holds reqN, addrN, wdataN and wrN stable until gntN is seen, and deasserts reqN on the next edge.
REQ-028 A requester that keeps reqN high after its grant is treated as a new request.
REQ-029 rdataN holds its value until the next read completion for that same port.
REQ-030 Only one of gnt0 / gnt1 is ever high at a time.
REQ-031 Only one of rvalid0 / rvalid1 is ever high at a time.
REQ-032 wren is high for exactly one cycle per accepted write and never during a read.
REQ-033 Address and data pass through unmodified, with no width conversion.
REQ-034 Fairness: under continuous contention grants alternate 0,1,0,1; no port waits more than one other transaction.

Reset
REQ-035 When reset=0, immediately and regardless of clock: state=IDLE and last_grant=1, so port 0 wins the first tie.
REQ-036 When reset=0, immediately: gnt0, gnt1, rvalid0, rvalid1, wren and busy are 0.
REQ-037 When reset=0, immediately: rdata0, rdata1, address_dmem and data are 0.
REQ-038 Reset mid-transaction aborts it: wren drops at once, and no rvalid is produced for an aborted read.
REQ-039 The first edge after reset rises to 1 evaluates requests normally.

Verification
REQ-040 Single read: dmem[0x005]=0xDEADBEEF; req0, addr0=0x005, wr0=0 -> gnt0 after E0, address_dmem=0x005, rvalid0 after E2 with rdata0=0xDEADBEEF.
REQ-041 Write then read: port 1 writes 0x12345678 to 0x00A -> wren=1 for exactly one cycle with address_dmem=0x00A; a following port 0 read of 0x00A returns 0x12345678.
REQ-042 Tie after reset: req0 and req1 reads held continuously -> grant order 0,1,0,1, with rvalid pulses on the matching port and never overlapping.
REQ-043 Back-to-back writes: req1 write only, reasserted immediately after each grant -> gnt1 every 2 cycles; a req0 raised meanwhile is granted at the next IDLE.
REQ-044 Reset during ISSUE of a write -> wren, gnt and busy are 0 immediately; after release no stale grant appears.
REQ-045 Reset during READ -> no rvalid; rdata0=rdata1=0.
